sqg_pattern_tx: RTL and testbench

Serial pattern transmitter: accepts a PAT_W-bit pattern with a repeat count and inter-frame gap over a valid/ready handshake, then drives it MSB-first, one bit per clock, on a serial output with a qualifying valid. It is the transmit-side counterpart of the team's serial sequence detectors. It serves as the stimulus source for those detectors and as a standalone framed-bit generator.

---
 rtl/sqg_pkg.sv | 12 +
 rtl/piso_shift.sv | 27 ++
 rtl/sqg_pattern_tx.sv | 142 ++++++++++++++
 tb/tb_sqg_pattern_tx.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sqg_pkg.sv
// Shared types and constants for the serial pattern transmitter family.
package sqg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } sqg_state_t;

  localparam logic [3:0] SQG_DEFAULT_PATTERN = 4'b0110;

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, serial-out shift register; MSB leaves first, load wins over shift.
module piso_shift #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[W-2:0], 1'b0};
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/sqg_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, reps times,
// with a programmable idle gap between frames.
module sqg_pattern_tx
  import sqg_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int unsigned BW = $clog2(PAT_W);
  localparam logic [BW-1:0] BIT_TOP = BW'(PAT_W - 1);

  sqg_state_t       state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0] frm_q, frm_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [GAP_W-1:0] gapcfg_q, gapcfg_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             done_q, done_d;
  logic             load, shift;
  logic [PAT_W-1:0] ld_pat;
  logic             msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q    <= '0;
      frm_q    <= '0;
      gcnt_q   <= '0;
      gapcfg_q <= '0;
      pat_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      bit_q    <= bit_d;
      frm_q    <= frm_d;
      gcnt_q   <= gcnt_d;
      gapcfg_q <= gapcfg_d;
      pat_q    <= pat_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    frm_d    = frm_q;
    gcnt_d   = gcnt_q;
    gapcfg_d = gapcfg_q;
    pat_d    = pat_q;
    done_d   = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    ld_pat   = pat_q;
    unique case (state_q)
      IDLE: begin
        // First frame loads straight from the input, the capture lands alongside it
        if (start_valid) begin
          pat_d    = pattern;
          gapcfg_d = gap;
          if (reps != '0) begin
            state_d = SEND;
            load    = 1'b1;
            ld_pat  = pattern;
            bit_d   = BIT_TOP;
            frm_d   = reps - CNT_W'(1);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (bit_q != '0) begin
          shift = 1'b1;
          bit_d = bit_q - BW'(1);
        end else if (frm_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (gapcfg_q == '0) begin
          load  = 1'b1;
          bit_d = BIT_TOP;
          frm_d = frm_q - CNT_W'(1);
        end else begin
          state_d = GAP;
          gcnt_d  = gapcfg_q - GAP_W'(1);
        end
      end
      GAP: begin
        if (gcnt_q != '0) begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end else begin
          state_d = SEND;
          load    = 1'b1;
          bit_d   = BIT_TOP;
          if (frm_q != '0) begin
            frm_d = frm_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  piso_shift #(
    .W(PAT_W)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (ld_pat),
    .msb   (msb)
  );

  assign sout_valid  = (state_q == SEND);
  assign sout        = msb & sout_valid;
  assign frame_start = sout_valid && (bit_q == BIT_TOP);
  assign busy        = (state_q != IDLE);
  assign start_ready = (state_q == IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_sqg_pattern_tx.sv
// Directed bench for sqg_pattern_tx: per-cycle output masks are hand-derived
// from the frame timing (bit k of a mask = expected value in cycle k).
module tb_sqg_pattern_tx;
  import sqg_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [3:0] pattern = '0;
  logic [7:0] reps = '0;
  logic [3:0] gap = '0;
  logic       sout, sout_valid, frame_start, done, busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  sqg_pattern_tx #(
    .PAT_W(4),
    .CNT_W(8),
    .GAP_W(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .pattern     (pattern),
    .reps        (reps),
    .gap         (gap),
    .sout        (sout),
    .sout_valid  (sout_valid),
    .frame_start (frame_start),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cycle(input string t, input int k, input logic [31:0] mv,
                             input logic [31:0] ms, input logic [31:0] mf,
                             input logic [31:0] md, input logic [31:0] mb);
    chk($sformatf("%s c%0d sout_valid", t, k), 32'(sout_valid), 32'(mv[k]));
    chk($sformatf("%s c%0d sout", t, k), 32'(sout), 32'(ms[k]));
    chk($sformatf("%s c%0d frame_start", t, k), 32'(frame_start), 32'(mf[k]));
    chk($sformatf("%s c%0d done", t, k), 32'(done), 32'(md[k]));
    chk($sformatf("%s c%0d busy", t, k), 32'(busy), 32'(mb[k]));
    chk($sformatf("%s c%0d start_ready", t, k), 32'(start_ready), 32'(!mb[k]));
  endtask

  task automatic run_cmd(input string t, input logic [3:0] p, input logic [7:0] r,
                         input logic [3:0] g, input int n, input logic [31:0] mv,
                         input logic [31:0] ms, input logic [31:0] mf,
                         input logic [31:0] md, input logic [31:0] mb);
    @(negedge clk);
    check_cycle(t, 0, mv, ms, mf, md, mb);
    start_valid = 1'b1;
    pattern     = p;
    reps        = r;
    gap         = g;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check_cycle(t, k, mv, ms, mf, md, mb);
      if (k == 1) begin
        start_valid = 1'b0;
        pattern     = ~p;
        reps        = 8'd5;
        gap         = 4'd7;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset sout_valid", 32'(sout_valid), 32'd0);
    chk("reset sout", 32'(sout), 32'd0);
    chk("reset frame_start", 32'(frame_start), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset start_ready", 32'(start_ready), 32'd1);

    run_cmd("single", SQG_DEFAULT_PATTERN, 8'd1, 4'd0, 6,
            32'h1E, 32'h0C, 32'h02, 32'h20, 32'h1E);
    run_cmd("gap2", 4'b1011, 8'd3, 4'd2, 18,
            32'h1E79E, 32'h1A69A, 32'h2082, 32'h20000, 32'h1FFFE);
    run_cmd("b2b", 4'b1001, 8'd2, 4'd0, 10,
            32'h1FE, 32'h132, 32'h22, 32'h200, 32'h1FE);
    run_cmd("reps0", 4'b1111, 8'd0, 4'd3, 3,
            32'h0, 32'h0, 32'h0, 32'h2, 32'h0);

    // start_valid held high; inputs churn while busy, second command taken in the done cycle
    @(negedge clk);
    check_cycle("hold", 0, 32'h3DE, 32'hCC, 32'h42, 32'h420, 32'h3DE);
    start_valid = 1'b1;
    pattern     = 4'b0110;
    reps        = 8'd1;
    gap         = 4'd0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check_cycle("hold", k, 32'h3DE, 32'hCC, 32'h42, 32'h420, 32'h3DE);
      if (k < 5) begin
        pattern = 4'b1111 ^ 4'(k);
        reps    = 8'd3;
        gap     = 4'd5;
      end else if (k == 5) begin
        pattern = 4'b1100;
        reps    = 8'd1;
        gap     = 4'd0;
      end else begin
        start_valid = 1'b0;
      end
    end

    // reset asserted mid-command, between clock edges
    @(negedge clk);
    start_valid = 1'b1;
    pattern     = 4'b1011;
    reps        = 8'd2;
    gap         = 4'd1;
    @(negedge clk);
    start_valid = 1'b0;
    chk("rst pre sout_valid", 32'(sout_valid), 32'd1);
    @(negedge clk);
    chk("rst pre busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst async sout_valid", 32'(sout_valid), 32'd0);
    chk("rst async busy", 32'(busy), 32'd0);
    chk("rst async frame_start", 32'(frame_start), 32'd0);
    chk("rst async sout", 32'(sout), 32'd0);
    chk("rst async start_ready", 32'(start_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst post c%0d done", k), 32'(done), 32'd0);
      chk($sformatf("rst post c%0d start_ready", k), 32'(start_ready), 32'd1);
      chk($sformatf("rst post c%0d sout_valid", k), 32'(sout_valid), 32'd0);
    end
    run_cmd("after_rst", 4'b0110, 8'd1, 4'd0, 6,
            32'h1E, 32'h0C, 32'h02, 32'h20, 32'h1E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
